// File: rtl/counter_pkg.sv
// Shared types and next-count arithmetic for the multi-channel up/down counter.
// The arithmetic runs at a fixed maximum width. The caller zero-extends its
// operands and keeps the low N bits of the value.
package counter_pkg;

  typedef enum logic {DIR_DN = 1'b0, DIR_UP = 1'b1} dir_e;
  typedef enum logic {MODE_WRAP = 1'b0, MODE_SAT = 1'b1} mode_e;

  localparam int unsigned CNT_W_MAX = 32;

  typedef logic [CNT_W_MAX-1:0] cnt_t;
  typedef logic [CNT_W_MAX:0]   wide_t;

  typedef struct packed {
    logic evt;
    cnt_t value;
  } next_t;

  // The event is the boundary crossing in the counting direction. The
  // arithmetic is one bit wider than CNT_W_MAX, so a carry out of bit n-1 is
  // always visible.
  function automatic next_t next_count(input cnt_t cur, input cnt_t step,
                                       input int unsigned n, input dir_e dir,
                                       input mode_e mode);
    wide_t one;
    wide_t maxv;
    wide_t sum;
    wide_t diff;
    wide_t value;
    logic  evt;
    next_t r;
    one  = wide_t'(1);
    maxv = (one << n) - one;
    sum  = wide_t'(cur) + wide_t'(step);
    diff = wide_t'(cur) - wide_t'(step);
    if (dir == DIR_UP) begin
      evt   = (sum > maxv);
      value = (mode == MODE_SAT && evt) ? maxv : (sum & maxv);
    end else begin
      evt   = (step > cur);
      value = (mode == MODE_SAT && evt) ? '0 : (diff & maxv);
    end
    r.evt   = evt;
    r.value = value[CNT_W_MAX-1:0];
    return r;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// One counter channel: the N-bit count register and the ovf/unf event pulses.
// When COUNTER_STICKY_STATUS_EN is defined, the channel also has sticky
// ovf/unf status bits.
module counter_channel
  import counter_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned S = 4
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_load,
  input  logic         i_dir,
  input  logic         i_sat,
  input  logic [S-1:0] i_step,
  input  logic [N-1:0] i_data,
`ifdef COUNTER_STICKY_STATUS_EN
  input  logic         i_sts_clr,
  output logic [1:0]   o_sts,
`endif
  output logic [N-1:0] o_result,
  output logic         o_ovf,
  output logic         o_unf
);

  next_t nxt;
  logic  ovf_n;
  logic  unf_n;
  logic  unused_nxt;

  // Next count and the qualified event for this cycle.
  always_comb begin
    nxt   = next_count(cnt_t'(o_result), cnt_t'(i_step), N, dir_e'(i_dir), mode_e'(i_sat));
    ovf_n = 1'b0;
    unf_n = 1'b0;
    if (!i_clr && i_en && !i_load) begin
      ovf_n = i_dir & nxt.evt;
      unf_n = ~i_dir & nxt.evt;
    end
  end

  // The value field is wider than N. Its upper bits are consumed here only.
  assign unused_nxt = ^nxt;

  // Count register. Priority: clear, hold when disabled, load, then count.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_result <= '0;
      o_ovf    <= 1'b0;
      o_unf    <= 1'b0;
    end else begin
      o_ovf <= ovf_n;
      o_unf <= unf_n;
      if (i_clr) begin
        o_result <= '0;
      end else if (i_en) begin
        if (i_load) o_result <= i_data;
        else        o_result <= nxt.value[N-1:0];
      end
    end
  end

`ifdef COUNTER_STICKY_STATUS_EN
  // Sticky status: bit 0 is ovf and bit 1 is unf. A new event wins over a
  // clear in the same cycle. i_clr does not affect these bits.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_sts <= '0;
    end else begin
      if (ovf_n)          o_sts[0] <= 1'b1;
      else if (i_sts_clr) o_sts[0] <= 1'b0;
      if (unf_n)          o_sts[1] <= 1'b1;
      else if (i_sts_clr) o_sts[1] <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/multi_updown_counter.sv
// NCH independent N-bit up/down counters with wrap or saturate modes.
// Optional sticky status is enabled by defining COUNTER_STICKY_STATUS_EN.
// This level only slices the packed buses and instantiates one channel each.
module multi_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned NCH = 4,
  parameter int unsigned S   = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic [NCH-1:0]   i_en,
  input  logic [NCH-1:0]   i_load,
  input  logic [NCH-1:0]   i_dir,
  input  logic [NCH-1:0]   i_sat,
  input  logic [NCH*S-1:0] i_step,
  input  logic [NCH*N-1:0] i_data,
`ifdef COUNTER_STICKY_STATUS_EN
  input  logic [NCH-1:0]   i_sts_clr,
  output logic [2*NCH-1:0] o_sts,
`endif
  output logic [NCH*N-1:0] o_result,
  output logic [NCH-1:0]   o_ovf,
  output logic [NCH-1:0]   o_unf
);

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    counter_channel #(
      .N (N),
      .S (S)
    ) u_ch (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_clr     (i_clr),
      .i_en      (i_en[k]),
      .i_load    (i_load[k]),
      .i_dir     (i_dir[k]),
      .i_sat     (i_sat[k]),
      .i_step    (i_step[k*S +: S]),
      .i_data    (i_data[k*N +: N]),
`ifdef COUNTER_STICKY_STATUS_EN
      .i_sts_clr (i_sts_clr[k]),
      .o_sts     (o_sts[2*k +: 2]),
`endif
      .o_result  (o_result[k*N +: N]),
      .o_ovf     (o_ovf[k]),
      .o_unf     (o_unf[k])
    );
  end

endmodule

// File: tb/tb_multi_updown_counter.sv
// Directed self-checking bench for multi_updown_counter (N=8, NCH=4, S=4).
// The sticky-status scenario runs only when COUNTER_STICKY_STATUS_EN is defined.
module tb_multi_updown_counter;

  localparam int unsigned N   = 8;
  localparam int unsigned NCH = 4;
  localparam int unsigned S   = 4;

  logic             i_clk;
  logic             i_rstn;
  logic             i_clr;
  logic [NCH-1:0]   i_en;
  logic [NCH-1:0]   i_load;
  logic [NCH-1:0]   i_dir;
  logic [NCH-1:0]   i_sat;
  logic [NCH*S-1:0] i_step;
  logic [NCH*N-1:0] i_data;
`ifdef COUNTER_STICKY_STATUS_EN
  logic [NCH-1:0]   i_sts_clr;
  logic [2*NCH-1:0] o_sts;
`endif
  logic [NCH*N-1:0] o_result;
  logic [NCH-1:0]   o_ovf;
  logic [NCH-1:0]   o_unf;

  int checks   = 0;
  int failures = 0;

  multi_updown_counter #(.N(N), .NCH(NCH), .S(S)) dut (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_clr     (i_clr),
    .i_en      (i_en),
    .i_load    (i_load),
    .i_dir     (i_dir),
    .i_sat     (i_sat),
    .i_step    (i_step),
    .i_data    (i_data),
`ifdef COUNTER_STICKY_STATUS_EN
    .i_sts_clr (i_sts_clr),
    .o_sts     (o_sts),
`endif
    .o_result  (o_result),
    .o_ovf     (o_ovf),
    .o_unf     (o_unf)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Advance one active edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_clr  = 1'b0;
    i_en   = '0;
    i_load = '0;
    i_dir  = '0;
    i_sat  = '0;
    i_step = '0;
    i_data = '0;
`ifdef COUNTER_STICKY_STATUS_EN
    i_sts_clr = '0;
`endif
  endtask

  task automatic test_reset();
    idle();
    i_rstn = 1'b0;
    #12;
    checks++; if (o_result !== 32'h0) begin failures++; $display("FAIL reset_result actual=%h required=%h", o_result, 32'h0); end
    checks++; if (o_ovf !== 4'h0) begin failures++; $display("FAIL reset_ovf actual=%b required=%b", o_ovf, 4'h0); end
    checks++; if (o_unf !== 4'h0) begin failures++; $display("FAIL reset_unf actual=%b required=%b", o_unf, 4'h0); end
    @(negedge i_clk);
    i_rstn = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    idle();
    i_en[0] = 1'b1; i_load[0] = 1'b1; i_data[7:0] = 8'd255;
    tick();
    checks++; if (o_result[7:0] !== 8'd255) begin failures++; $display("FAIL wrap_load actual=%0d required=255", o_result[7:0]); end
    i_load[0] = 1'b0; i_dir[0] = 1'b1; i_step[3:0] = 4'd1;
    tick();
    checks++; if (o_result[7:0] !== 8'd0) begin failures++; $display("FAIL wrap_up_result actual=%0d required=0", o_result[7:0]); end
    checks++; if (o_ovf !== 4'b0001) begin failures++; $display("FAIL wrap_up_ovf actual=%b required=0001", o_ovf); end
    i_en[0] = 1'b0;
    tick();
    checks++; if (o_ovf !== 4'b0000) begin failures++; $display("FAIL wrap_ovf_pulse actual=%b required=0000", o_ovf); end
    checks++; if (o_result[7:0] !== 8'd0) begin failures++; $display("FAIL wrap_hold actual=%0d required=0", o_result[7:0]); end
    i_en[0] = 1'b1; i_dir[0] = 1'b0;
    tick();
    checks++; if (o_result[7:0] !== 8'd255) begin failures++; $display("FAIL wrap_dn_result actual=%0d required=255", o_result[7:0]); end
    checks++; if (o_unf !== 4'b0001) begin failures++; $display("FAIL wrap_dn_unf actual=%b required=0001", o_unf); end
  endtask

  task automatic test_saturate();
    idle();
    i_en[1] = 1'b1; i_load[1] = 1'b1; i_data[15:8] = 8'd2;
    tick();
    i_load[1] = 1'b0; i_sat[1] = 1'b1; i_dir[1] = 1'b0; i_step[7:4] = 4'd3;
    tick();
    checks++; if (o_result[15:8] !== 8'd0) begin failures++; $display("FAIL sat_dn_result actual=%0d required=0", o_result[15:8]); end
    checks++; if (o_unf !== 4'b0010) begin failures++; $display("FAIL sat_dn_unf actual=%b required=0010", o_unf); end
    tick();
    checks++; if (o_result[15:8] !== 8'd0) begin failures++; $display("FAIL sat_dn_hold actual=%0d required=0", o_result[15:8]); end
    checks++; if (o_unf !== 4'b0010) begin failures++; $display("FAIL sat_dn_unf_again actual=%b required=0010", o_unf); end
    i_load[1] = 1'b1; i_data[15:8] = 8'd250;
    tick();
    i_load[1] = 1'b0; i_dir[1] = 1'b1; i_step[7:4] = 4'd4;
    tick();
    checks++; if (o_result[15:8] !== 8'd254 || o_ovf !== 4'b0000) begin failures++; $display("FAIL sat_up_254 actual=%0d/%b required=254/0000", o_result[15:8], o_ovf); end
    tick();
    checks++; if (o_result[15:8] !== 8'd255 || o_ovf !== 4'b0010) begin failures++; $display("FAIL sat_up_clamp actual=%0d/%b required=255/0010", o_result[15:8], o_ovf); end
    tick();
    checks++; if (o_result[15:8] !== 8'd255 || o_ovf !== 4'b0010) begin failures++; $display("FAIL sat_up_reassert actual=%0d/%b required=255/0010", o_result[15:8], o_ovf); end
  endtask

  task automatic test_load_hold();
    idle();
    i_en[2] = 1'b1; i_load[2] = 1'b1; i_dir[2] = 1'b1; i_step[11:8] = 4'd1; i_data[23:16] = 8'hA5;
    tick();
    checks++; if (o_result[23:16] !== 8'hA5) begin failures++; $display("FAIL load_value actual=%h required=a5", o_result[23:16]); end
    checks++; if (o_ovf !== 4'b0000 || o_unf !== 4'b0000) begin failures++; $display("FAIL load_no_event actual=%b/%b required=0000/0000", o_ovf, o_unf); end
    i_en[2] = 1'b0; i_data[23:16] = 8'h11;
    tick();
    checks++; if (o_result[23:16] !== 8'hA5) begin failures++; $display("FAIL load_disabled_hold actual=%h required=a5", o_result[23:16]); end
  endtask

  task automatic test_step_zero();
    idle();
    i_en[3] = 1'b1; i_load[3] = 1'b1; i_data[31:24] = 8'h40;
    tick();
    i_load[3] = 1'b0; i_dir[3] = 1'b1; i_step[15:12] = 4'd0;
    tick();
    checks++; if (o_result[31:24] !== 8'h40 || o_ovf !== 4'b0000) begin failures++; $display("FAIL step0_up actual=%h/%b required=40/0000", o_result[31:24], o_ovf); end
    i_dir[3] = 1'b0;
    tick();
    checks++; if (o_result[31:24] !== 8'h40 || o_unf !== 4'b0000) begin failures++; $display("FAIL step0_dn actual=%h/%b required=40/0000", o_result[31:24], o_unf); end
  endtask

  task automatic test_clear();
    idle();
    i_en = 4'hF; i_load = 4'hF; i_data = {8'd40, 8'd30, 8'd20, 8'd10};
    tick();
    i_load = 4'h0; i_dir = 4'b0101; i_step = 16'h1111;
    tick();
    checks++; if (o_result !== {8'd39, 8'd31, 8'd19, 8'd11}) begin failures++; $display("FAIL independent_count actual=%h required=%h", o_result, {8'd39, 8'd31, 8'd19, 8'd11}); end
    i_clr = 1'b1; i_en = 4'h0;
    tick();
    checks++; if (o_result !== 32'h0) begin failures++; $display("FAIL clear_result actual=%h required=0", o_result); end
    checks++; if (o_ovf !== 4'h0 || o_unf !== 4'h0) begin failures++; $display("FAIL clear_no_event actual=%b/%b required=0000/0000", o_ovf, o_unf); end
  endtask

  task automatic test_async_reset();
    idle();
    i_en = 4'hF; i_dir = 4'hF; i_step = 16'h1111;
    tick(); tick(); tick();
    checks++; if (o_result !== 32'h03030303) begin failures++; $display("FAIL midcount actual=%h required=03030303", o_result); end
    #2 i_rstn = 1'b0;
    #1;
    checks++; if (o_result !== 32'h0) begin failures++; $display("FAIL async_reset_result actual=%h required=0", o_result); end
    #1 i_rstn = 1'b1;
    tick();
    checks++; if (o_result !== 32'h01010101) begin failures++; $display("FAIL resume_after_reset actual=%h required=01010101", o_result); end
  endtask

`ifdef COUNTER_STICKY_STATUS_EN
  task automatic test_sticky();
    idle();
    @(negedge i_clk);
    i_rstn = 1'b0;
    #1;
    checks++; if (o_sts !== 8'h00) begin failures++; $display("FAIL sticky_reset actual=%b required=00000000", o_sts); end
    i_rstn = 1'b1;
    i_en[3] = 1'b1; i_load[3] = 1'b1; i_data[31:24] = 8'd255;
    tick();
    i_load[3] = 1'b0; i_dir[3] = 1'b1; i_step[15:12] = 4'd1; i_sts_clr[3] = 1'b1;
    tick();
    checks++; if (o_sts[6] !== 1'b1 || o_ovf[3] !== 1'b1) begin failures++; $display("FAIL sticky_set_wins actual=%b/%b required=1/1", o_sts[6], o_ovf[3]); end
    i_en[3] = 1'b0; i_sts_clr[3] = 1'b0; i_clr = 1'b1;
    tick();
    checks++; if (o_sts[6] !== 1'b1) begin failures++; $display("FAIL sticky_survives_clr actual=%b required=1", o_sts[6]); end
    i_clr = 1'b0; i_sts_clr[3] = 1'b1;
    tick();
    checks++; if (o_sts[6] !== 1'b0) begin failures++; $display("FAIL sticky_clear actual=%b required=0", o_sts[6]); end
  endtask
`endif

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_load_hold();
    test_step_zero();
    test_clear();
    test_async_reset();
`ifdef COUNTER_STICKY_STATUS_EN
    test_sticky();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
